// File: rtl/tone_noise_tracker.sv
// Tracks a 23-bit SID-style noise generator from its 8-bit tapped output word, flywheels the
// reconstructed LFSR and flags deviations. Optional error counter: NOISE_TRACKER_ERRCNT_EN.
module tone_noise_tracker #(
  parameter int unsigned INPUT_BITS  = 12,
  parameter int unsigned LOSS_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INPUT_BITS-1:0] din,
  input  logic                  din_valid,
  output logic                  locked,
  output logic                  err_pulse,
  output logic [15:0]           err_count,
  output logic [22:0]           state_out
);

  typedef enum logic {StAcquire, StLocked} state_e;

  state_e      state_q;
  logic [22:0] r_q;
  logic [4:0]  acq_cnt_q;
  logic [3:0]  miss_q;
  logic        err_pulse_q;

  logic [7:0]  taps;
  logic [22:0] r_acq;
  logic [22:0] r_pred;
  logic [7:0]  pred_taps;
  logic        mismatch;

  assign taps = din[INPUT_BITS-1 -: 8];

  // R runs two steps behind the generator, so generator taps 22,20,... land on R[20],R[18],...
  assign r_acq     = {r_q[21:0], taps[0]};
  assign r_pred    = {r_q[21:0], r_q[22] ^ r_q[17]};
  assign pred_taps = {r_pred[20], r_pred[18], r_pred[14], r_pred[11],
                      r_pred[9], r_pred[5], r_pred[2], r_pred[0]};
  assign mismatch  = (pred_taps != taps);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StAcquire;
      r_q         <= '0;
      acq_cnt_q   <= '0;
      miss_q      <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      err_pulse_q <= 1'b0;
      if (din_valid) begin
        unique case (state_q)
          StAcquire: begin
            r_q <= r_acq;
            if (acq_cnt_q == 5'd22) begin
              acq_cnt_q <= '0;
              // An all-zero register is not a reachable LFSR state: keep acquiring.
              if (r_acq != '0) begin
                state_q <= StLocked;
                miss_q  <= '0;
              end
            end else begin
              acq_cnt_q <= acq_cnt_q + 5'd1;
            end
          end
          StLocked: begin
            if (mismatch) begin
              err_pulse_q <= 1'b1;
              if (miss_q == 4'(LOSS_THRESH - 1)) begin
                state_q   <= StAcquire;
                r_q       <= '0;
                acq_cnt_q <= '0;
                miss_q    <= '0;
              end else begin
                r_q    <= r_pred;
                miss_q <= miss_q + 4'd1;
              end
            end else begin
              r_q    <= r_pred;
              miss_q <= '0;
            end
          end
        endcase
      end
    end
  end

  assign locked    = (state_q == StLocked);
  assign err_pulse = err_pulse_q;
  assign state_out = r_q;

`ifdef NOISE_TRACKER_ERRCNT_EN
  logic [15:0] err_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_q <= '0;
    end else if (din_valid && (state_q == StLocked) && mismatch && (err_count_q != 16'hFFFF)) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_tone_noise_tracker.sv
// Scoreboard bench for tone_noise_tracker: a reference noise generator drives the tracker and
// the expected outputs for every cycle are queued for an independent monitor.
module tb_tone_noise_tracker;

  localparam int unsigned INW  = 12;
  localparam int unsigned LOSS = 4;
`ifdef NOISE_TRACKER_ERRCNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [INW-1:0] din = '0;
  logic           din_valid = 1'b0;
  logic           locked;
  logic           err_pulse;
  logic [15:0]    err_count;
  logic [22:0]    state_out;

  always #5 clk = ~clk;

  tone_noise_tracker #(
    .INPUT_BITS (INW),
    .LOSS_THRESH(LOSS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_valid(din_valid),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .state_out(state_out)
  );

  typedef struct packed {
    logic        lk;
    logic        ep;
    logic [15:0] ec;
    logic [22:0] r;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // gen[k] = feedback bit s(j-k); gen[22:0] is the generator state, gen[24:2] the state two
  // steps back.
  logic [24:0] gen;
  int          m_n;
  int          m_miss;
  logic        m_lk;
  logic [15:0] m_cnt;
  logic [22:0] m_r;

  function automatic logic [7:0] taps_of(input logic [22:0] l);
    return {l[22], l[20], l[16], l[13], l[11], l[7], l[4], l[2]};
  endfunction

  function automatic logic [22:0] mask_of(input int n);
    if (n >= 23) return '1;
    return (23'd1 << n) - 23'd1;
  endfunction

  task automatic model_reset();
    gen    = {2'b00, 23'h7FFFF8};
    m_n    = 0;
    m_miss = 0;
    m_lk   = 1'b0;
    m_cnt  = '0;
    m_r    = '0;
  endtask

  task automatic step(input bit valid, input bit corrupt, input bit zero);
    exp_t        e;
    logic [7:0]  t;
    logic [31:0] rnd;
    @(negedge clk);
    t = zero ? 8'h00 : taps_of(gen[22:0]);
    if (corrupt) t[7] = ~t[7];
    rnd = $urandom;
    din[INW-1 -: 8] = t;
    din[INW-9:0]    = rnd[INW-9:0];
    din_valid       = valid;
    e.ep = 1'b0;
    if (valid) begin
      if (!m_lk) begin
        m_n++;
        if (zero) begin
          m_r = '0;
          if (m_n == 23) m_n = 0;
        end else begin
          m_r = gen[24:2] & mask_of(m_n);
          if (m_n == 23) begin
            m_lk = 1'b1;
            m_n  = 0;
          end
        end
      end else begin
        m_r = gen[24:2];
        if (corrupt) begin
          e.ep = 1'b1;
          if (m_cnt != 16'hFFFF) m_cnt++;
          m_miss++;
          if (m_miss == int'(LOSS)) begin
            m_lk   = 1'b0;
            m_miss = 0;
            m_r    = '0;
          end
        end else begin
          m_miss = 0;
        end
      end
      if (!zero) gen = {gen[23:0], gen[22] ^ gen[17]};
    end
    e.lk = m_lk;
    e.ec = CntEn ? m_cnt : 16'd0;
    e.r  = m_r;
    sb_q.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [40:0] got, input logic [40:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Monitor: the DUT presents a result every cycle; compare against the queued expectation.
  initial begin
    exp_t mon_e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        n_vec++;
        if ({locked, err_pulse, err_count, state_out} !== mon_e) begin
          n_fail++;
          $display("FAIL scoreboard @%0t: got lk=%b ep=%b ec=%0d r=%h, want lk=%b ep=%b ec=%0d r=%h",
                   $time, locked, err_pulse, err_count, state_out,
                   mon_e.lk, mon_e.ep, mon_e.ec, mon_e.r);
        end
      end
    end
  end

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic async_reset(input string name);
    @(posedge clk);
    #3;
    din_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_now(name, {locked, err_pulse, err_count, state_out}, 41'd0);
    model_reset();
  endtask

  initial begin
    model_reset();
    #2 rst = 1'b1;
    #2;
    check_now("reset_outputs", {locked, err_pulse, err_count, state_out}, 41'd0);
    release_reset();

    // Continuous clean stream: lock after 23 samples, then long error-free run.
    for (int i = 0; i < 10000; i++) step(1'b1, 1'b0, 1'b0);

    // Single corrupted MSB tap while locked.
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b0);

    // LOSS consecutive misses drop lock; clean data re-locks after 23 fresh samples.
    for (int i = 0; i < int'(LOSS); i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0);
    async_reset("reset_while_locked");
    release_reset();

    // All-zero input must never lock.
    for (int i = 0; i < 1000; i++) step(1'b1, 1'b0, 1'b1);
    async_reset("reset_after_zero_din");
    release_reset();

    // Generator stepped every third cycle.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end

    @(posedge clk);
    #3;
    check_now("queue_drained", 41'(sb_q.size()), 41'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
